// File: rtl/fetch_ctrl.sv
// Instruction fetch control: in-order imem requests, tagged response
// buffer, redirect flush and drain of stale in-flight responses.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [31:0] mispredict_addr,
  input  logic        br_guess,
  input  logic [31:0] br_guess_addr,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  state_e        state_q;
  state_e        state_d;
  logic [31:0]   npc_q;
  logic [31:0]   npc_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;

  logic [31:0]   pcq_mem [DEPTH];
  logic [PW-1:0] pcq_rd;
  logic [PW-1:0] pcq_wr;
  logic [CW-1:0] pcq_cnt;

  ent_t          rsq_mem [DEPTH];
  logic [PW-1:0] rsq_rd;
  logic [PW-1:0] rsq_wr;
  logic [CW-1:0] rsq_cnt;

  logic          pop;
  logic          br_take;
  logic          flush;
  logic          resp_ok;
  logic          push;
  logic          drain_rsp;
  logic          issue;
  logic [CW-1:0] outst;
  logic [OW-1:0] occ;
  ent_t          head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  assign head        = rsq_mem[rsq_rd];
  assign fetch_valid = (rsq_cnt != '0);
  assign fetch_pc    = fetch_valid ? head.pc : '0;
  assign fetch_instr = fetch_valid ? head.instr : '0;
  assign imem_addr   = npc_q;
  assign imem_rmask  = issue ? 4'hF : 4'h0;

  always_comb begin
    pop       = fetch_valid & ~stall;
    br_take   = br_guess & pop & ~mispredict;
    flush     = mispredict | br_take;
    // drop is only nonzero in DRAIN, where the PC queue is empty
    outst     = pcq_cnt + drop_q;
    resp_ok   = imem_resp & (outst != '0);
    push      = resp_ok & (state_q == RUN) & ~flush;
    drain_rsp = resp_ok & (state_q == DRAIN) & ~flush;
    occ       = OW'(pcq_cnt) + OW'(rsq_cnt) - OW'(pop);
    issue     = rst & (state_q == RUN) & ~flush
              & (occ < OW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    drop_d  = drop_q;
    unique case (1'b1)
      flush: begin
        npc_d   = mispredict ? mispredict_addr
                             : br_guess_addr;
        drop_d  = outst - CW'(resp_ok);
        state_d = (drop_d != '0) ? DRAIN : RUN;
      end
      drain_rsp: begin
        drop_d  = drop_q - CW'(1);
        state_d = (drop_d != '0) ? DRAIN : RUN;
      end
      issue: begin
        npc_d = npc_q + 32'd4;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      npc_q   <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcq_rd  <= '0;
      pcq_wr  <= '0;
      pcq_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_mem[i] <= '0;
      end
    end else if (flush) begin
      pcq_rd  <= '0;
      pcq_wr  <= '0;
      pcq_cnt <= '0;
    end else begin
      if (issue) begin
        pcq_mem[pcq_wr] <= npc_q;
        pcq_wr          <= nxt(pcq_wr);
      end
      if (push) begin
        pcq_rd <= nxt(pcq_rd);
      end
      pcq_cnt <= pcq_cnt + CW'(issue) - CW'(push);
    end
  end

  // A taken guess consumes the head, so every buffered entry goes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsq_rd  <= '0;
      rsq_wr  <= '0;
      rsq_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rsq_mem[i] <= '0;
      end
    end else if (flush) begin
      rsq_rd  <= '0;
      rsq_wr  <= '0;
      rsq_cnt <= '0;
    end else begin
      if (push) begin
        rsq_mem[rsq_wr] <= '{
          pc:    pcq_mem[pcq_rd],
          instr: imem_rdata
        };
        rsq_wr <= nxt(rsq_wr);
      end
      if (pop) begin
        rsq_rd <= nxt(rsq_rd);
      end
      rsq_cnt <= rsq_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed redirect scenarios plus random
// traffic against a queue-based model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC   = 32'h6000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        mispredict = 1'b0;
  logic [31:0] mispredict_addr = '0;
  logic        br_guess = 1'b0;
  logic [31:0] br_guess_addr = '0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid;

  fetch_ctrl #(
    .RESET_PC(RPC),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .mispredict(mispredict),
    .mispredict_addr(mispredict_addr),
    .br_guess(br_guess),
    .br_guess_addr(br_guess_addr),
    .imem_addr(imem_addr),
    .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic [31:0] m_live[$];
  ent_t        m_buf[$];
  int          m_drop;
  logic [31:0] m_npc;
  logic [31:0] mem_q[$];

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [3:0]  obs_rmask;
  logic [31:0] obs_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live.delete();
    m_buf.delete();
    mem_q.delete();
    m_drop = 0;
    m_npc  = RPC;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    mispredict = 1'b0;
    br_guess = 1'b0;
    imem_resp = 1'b0;
    #1;
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_rmask", 32'(imem_rmask), 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // mode 0: respond asap, 1: random (+spurious), 2: never
  task automatic step(input bit st, input bit mp,
                      input logic [31:0] mpa, input bit bg,
                      input logic [31:0] bga, input int mode);
    bit          rsp;
    bit          got;
    bit          pop;
    bit          brt;
    bit          iss;
    int          occ;
    logic [31:0] rd;
    logic [31:0] pcx;
    rsp = 1'b0;
    got = 1'b0;
    rd  = '0;
    pcx = '0;
    if (mem_q.size() > 0) begin
      if (mode == 0 || (mode == 1 && $urandom_range(1, 0) == 1)) begin
        rsp = 1'b1;
        rd  = instr_of(mem_q[0]);
        void'(mem_q.pop_front());
      end
    end else if (mode == 1 && $urandom_range(7, 0) == 0) begin
      rsp = 1'b1;
      rd  = $urandom;
    end
    stall = st;
    mispredict = mp;
    mispredict_addr = mpa;
    br_guess = bg;
    br_guess_addr = bga;
    imem_resp = rsp;
    imem_rdata = rd;
    @(negedge clk);
    pop = (m_buf.size() > 0) && !st;
    brt = bg && pop && !mp;
    occ = m_live.size() + m_buf.size() - int'(pop);
    iss = (m_drop == 0) && !mp && !brt && (occ < DEPTH);
    obs_rmask = imem_rmask;
    obs_addr  = imem_addr;
    chk("rmask", 32'(imem_rmask), iss ? 32'hF : 32'h0);
    if (iss) chk("imem_addr", imem_addr, m_npc);
    chk("valid", 32'(fetch_valid), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      chk("fetch_pc", fetch_pc, m_buf[0].pc);
      chk("fetch_instr", fetch_instr, m_buf[0].ins);
    end
    if (imem_rmask == 4'hF) mem_q.push_back(imem_addr);
    if (rsp) begin
      if (m_drop > 0) m_drop--;
      else if (m_live.size() > 0) begin
        pcx = m_live.pop_front();
        got = 1'b1;
      end
    end
    if (pop) void'(m_buf.pop_front());
    if (mp || brt) begin
      m_drop += m_live.size();
      m_live.delete();
      m_buf.delete();
      m_npc = mp ? mpa : bga;
    end else begin
      if (got) m_buf.push_back('{pcx, rd});
      if (iss) begin
        m_live.push_back(m_npc);
        m_npc = m_npc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pc(input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    while (!(fetch_valid && fetch_pc == pc) && n < budget) begin
      step(1'b0, 1'b0, '0, 1'b0, '0, 0);
      n++;
    end
    chk("reach_valid", 32'(fetch_valid), 32'd1);
    chk("reach_pc", fetch_pc, pc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    bit seen;
    #2;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, '0, 0);
      chk("seq_mask", 32'(obs_rmask), 32'hF);
      chk("seq_addr", obs_addr, RPC + 32'(4 * i));
      if (i > 0) chk("seq_pc", fetch_pc, RPC + 32'(4 * (i - 1)));
    end

    do_reset();
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, '0, 0);
      if (obs_rmask == 4'hF) issues++;
    end
    chk("stall_issues", 32'(issues), 32'd2);
    chk("stall_idle", 32'(obs_rmask), 32'd0);
    chk("stall_head", fetch_pc, RPC);
    step(1'b0, 1'b0, '0, 1'b0, '0, 0);
    chk("resume_mask", 32'(obs_rmask), 32'hF);
    chk("resume_addr", obs_addr, RPC + 32'h8);
    chk("resume_pc", fetch_pc, RPC + 32'h4);

    do_reset();
    run_until_pc(RPC + 32'h4, 10);
    step(1'b0, 1'b0, '0, 1'b0, '0, 2);
    chk("pre_mp_addr", obs_addr, RPC + 32'hC);
    step(1'b0, 1'b1, 32'h6000_1000, 1'b0, '0, 2);
    chk("mp_noissue", 32'(obs_rmask), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, '0, 0);
      chk("drain_mask", 32'(obs_rmask), 32'd0);
      chk("drain_valid", 32'(fetch_valid), 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b0, '0, 0);
    chk("redir_mask", 32'(obs_rmask), 32'hF);
    chk("redir_addr", obs_addr, 32'h6000_1000);
    run_until_pc(32'h6000_1000, 10);

    do_reset();
    run_until_pc(RPC + 32'h10, 20);
    step(1'b1, 1'b0, '0, 1'b0, '0, 0);
    chk("bg_hold", fetch_pc, RPC + 32'h10);
    step(1'b0, 1'b0, '0, 1'b1, 32'h6000_2000, 0);
    chk("bg_flush", 32'(fetch_valid), 32'd0);
    run_until_pc(32'h6000_2000, 10);

    step(1'b0, 1'b1, 32'h6000_3000, 1'b1, 32'h6000_4000, 0);
    chk("both_flush", 32'(fetch_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !fetch_valid; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, '0, 0);
      if (obs_rmask == 4'hF && obs_addr == 32'h6000_4000) seen = 1'b1;
    end
    chk("both_pc", fetch_pc, 32'h6000_3000);
    chk("bg_never", 32'(seen), 32'd0);

    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, '0, 0);
    run_until_pc(32'hFFFF_FFFC, 12);
    run_until_pc(32'h0000_0000, 4);

    step(1'b0, 1'b1, 32'h6000_5000, 1'b0, '0, 2);
    step(1'b0, 1'b0, '0, 1'b0, '0, 2);
    chk("drain_hold", 32'(obs_rmask), 32'd0);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0, 0);
    chk("post_rst_mask", 32'(obs_rmask), 32'hF);
    chk("post_rst_addr", obs_addr, RPC);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(2, 0) == 0, $urandom_range(23, 0) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(4, 0) == 0,
           $urandom & 32'hFFFF_FFFC,
           ($urandom_range(15, 0) == 0) ? 0 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
